// File: rtl/axi_slave_mem.sv
// ----------------------------------------------------------------------------
// axi_slave_mem
//
// Simplified AXI-style byte-wide slave memory. The write channel accepts an
// address (AW), a burst of data bytes (W) and returns a single response (B).
// The read channel independently accepts an address plus burst length (AR) and
// streams the bytes back (R). Both channels run concurrently against one array.
//
// Addresses at or above DEPTH have no backing storage: writes there are
// dropped and flagged SLVERR on B, reads there return 0x00 with SLVERR on
// that beat. Burst addresses wrap modulo 256.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   AWVALID/AWREADY/AWADDR/AWID   write address channel
//   WVALID/WREADY/WDATA/WLAST     write data channel (one byte per beat)
//   BVALID/BREADY/BID/BRESP       write response (BRESP 1 = SLVERR)
//   ARVALID/ARREADY/ARADDR/ARLEN/ARID  read address channel (ARLEN = beats-1)
//   RVALID/RREADY/RDATA/RID/RRESP/RLAST  read data channel
// ----------------------------------------------------------------------------
module axi_slave_mem #(
    parameter int DEPTH = 256,
    parameter int ID_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    // write address
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [7:0]      AWADDR,
    input  logic [ID_W-1:0] AWID,
    // write data
    input  logic            WVALID,
    output logic            WREADY,
    input  logic [7:0]      WDATA,
    input  logic            WLAST,
    // write response
    output logic            BVALID,
    input  logic            BREADY,
    output logic [ID_W-1:0] BID,
    output logic            BRESP,
    // read address
    input  logic            ARVALID,
    output logic            ARREADY,
    input  logic [7:0]      ARADDR,
    input  logic [3:0]      ARLEN,
    input  logic [ID_W-1:0] ARID,
    // read data
    output logic            RVALID,
    input  logic            RREADY,
    output logic [7:0]      RDATA,
    output logic [ID_W-1:0] RID,
    output logic            RRESP,
    output logic            RLAST
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    function automatic logic in_range(input logic [7:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [7:0]       mem_wdata;

    // ------------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------------
    logic [1:0]      w_state_q, w_state_d;
    logic [7:0]      waddr_q,   waddr_d;
    logic [ID_W-1:0] bid_q,     bid_d;
    logic            werr_q,    werr_d;

    // ------------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------------
    logic            r_state_q, r_state_d;
    logic [7:0]      raddr_q,   raddr_d;
    logic [3:0]      rlen_q,    rlen_d;
    logic [3:0]      rbeat_q,   rbeat_d;
    logic [ID_W-1:0] rid_q,     rid_d;
    logic [7:0]      rdata_q,   rdata_d;
    logic            rresp_q,   rresp_d;
    logic            rlast_q,   rlast_d;

    // Address whose byte is loaded into the R output register on the next
    // edge: the start address while idle, otherwise the following beat.
    logic [7:0] fetch_addr;
    logic       fetch_ok;
    logic [7:0] fetch_data;

    always_comb begin
        fetch_addr = (r_state_q == R_IDLE) ? ARADDR : (raddr_q + 8'd1);
        fetch_ok   = in_range(fetch_addr);
        fetch_data = fetch_ok ? mem_q[fetch_addr[IDX_W-1:0]] : 8'h00;
    end

    // ------------------------------------------------------------------------
    // Write FSM next-state
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        bid_d     = bid_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = WDATA;

        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    waddr_d   = AWADDR;
                    bid_d     = AWID;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    if (in_range(waddr_q)) begin
                        mem_we   = 1'b1;
                        mem_widx = waddr_q[IDX_W-1:0];
                    end else begin
                        werr_d = 1'b1;
                    end
                    waddr_d = waddr_q + 8'd1;
                    if (WLAST) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read FSM next-state
    // ------------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;

        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    raddr_d   = ARADDR;
                    rlen_d    = ARLEN;
                    rid_d     = ARID;
                    rbeat_d   = 4'd0;
                    rdata_d   = fetch_data;
                    rresp_d   = ~fetch_ok;
                    rlast_d   = (ARLEN == 4'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // Outputs only change on acceptance, so they hold while stalled.
                if (RREADY) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        // Load the next beat on the accepting edge: no bubble.
                        raddr_d = fetch_addr;
                        rbeat_d = rbeat_q + 4'd1;
                        rdata_d = fetch_data;
                        rresp_d = ~fetch_ok;
                        rlast_d = ((rbeat_q + 4'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            waddr_q   <= 8'h00;
            bid_q     <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            raddr_q   <= 8'h00;
            rlen_q    <= 4'd0;
            rbeat_q   <= 4'd0;
            rid_q     <= '0;
            rdata_q   <= 8'h00;
            rresp_q   <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            bid_q     <= bid_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // NOTE: the array is cleared on reset because the contents must read back
    // as 0x00 afterwards; this makes it a register file rather than an inferred
    // RAM macro, which is acceptable at this size.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign AWREADY = (w_state_q == W_IDLE);
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BID     = bid_q;
    assign BRESP   = werr_q;

    assign ARREADY = (r_state_q == R_IDLE);
    assign RVALID  = (r_state_q == R_DATA);
    assign RDATA   = rdata_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_axi_slave_mem
//
// Two instances share all inputs: a full 256-byte memory and a 128-byte one
// used for the out-of-range cases. sel_small picks which instance's outputs
// are observed. Expected B and R responses come from a byte model per
// instance and are queued when the address phase is driven, then popped as
// the DUT presents them.
// ----------------------------------------------------------------------------
module tb_axi_slave_mem;

    localparam int ID_W = 4;

    typedef struct packed {
        logic [3:0] id;
        logic       resp;
    } b_exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       resp;
        logic       last;
        logic [3:0] id;
    } r_exp_t;

    logic clk = 1'b0;
    logic rst;

    logic            AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
    logic [7:0]      AWADDR, WDATA, ARADDR;
    logic [ID_W-1:0] AWID, ARID;
    logic [3:0]      ARLEN;

    // big instance outputs
    logic            b_awready, b_wready, b_bvalid, b_bresp, b_arready;
    logic            b_rvalid, b_rresp, b_rlast;
    logic [ID_W-1:0] b_bid, b_rid;
    logic [7:0]      b_rdata;
    // small instance outputs
    logic            s_awready, s_wready, s_bvalid, s_bresp, s_arready;
    logic            s_rvalid, s_rresp, s_rlast;
    logic [ID_W-1:0] s_bid, s_rid;
    logic [7:0]      s_rdata;

    logic sel_small;

    logic            AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST;
    logic [ID_W-1:0] BID, RID;
    logic [7:0]      RDATA;

    assign AWREADY = sel_small ? s_awready : b_awready;
    assign WREADY  = sel_small ? s_wready  : b_wready;
    assign BVALID  = sel_small ? s_bvalid  : b_bvalid;
    assign BRESP   = sel_small ? s_bresp   : b_bresp;
    assign BID     = sel_small ? s_bid     : b_bid;
    assign ARREADY = sel_small ? s_arready : b_arready;
    assign RVALID  = sel_small ? s_rvalid  : b_rvalid;
    assign RRESP   = sel_small ? s_rresp   : b_rresp;
    assign RLAST   = sel_small ? s_rlast   : b_rlast;
    assign RID     = sel_small ? s_rid     : b_rid;
    assign RDATA   = sel_small ? s_rdata   : b_rdata;

    always #5 clk = ~clk;

    axi_slave_mem #(.DEPTH(256), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWREADY(b_awready), .AWADDR(AWADDR), .AWID(AWID),
        .WVALID(WVALID), .WREADY(b_wready), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(b_bvalid), .BREADY(BREADY), .BID(b_bid), .BRESP(b_bresp),
        .ARVALID(ARVALID), .ARREADY(b_arready), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
        .RVALID(b_rvalid), .RREADY(RREADY), .RDATA(b_rdata), .RID(b_rid),
        .RRESP(b_rresp), .RLAST(b_rlast)
    );

    axi_slave_mem #(.DEPTH(128), .ID_W(ID_W)) dut_small (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWREADY(s_awready), .AWADDR(AWADDR), .AWID(AWID),
        .WVALID(WVALID), .WREADY(s_wready), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(s_bvalid), .BREADY(BREADY), .BID(s_bid), .BRESP(s_bresp),
        .ARVALID(ARVALID), .ARREADY(s_arready), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
        .RVALID(s_rvalid), .RREADY(RREADY), .RDATA(s_rdata), .RID(s_rid),
        .RRESP(s_rresp), .RLAST(s_rlast)
    );

    // ------------------------------------------------------------------------
    // Model and scoreboard
    // ------------------------------------------------------------------------
    logic [7:0] model_big   [256];
    logic [7:0] model_small [256];
    b_exp_t     bq[$];
    r_exp_t     rq[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic tb_in_range(input logic [7:0] a);
        return sel_small ? (a < 8'd128) : 1'b1;
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (!tb_in_range(a)) return 8'h00;
        return sel_small ? model_small[a] : model_big[a];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            model_big[i]   = 8'h00;
            model_small[i] = 8'h00;
        end
    endtask

    // ------------------------------------------------------------------------
    // Write burst of up to three bytes, with B held one stall cycle
    // ------------------------------------------------------------------------
    task automatic do_write(input logic [7:0] addr, input logic [3:0] id, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic       err;
        logic [7:0] a;
        logic [7:0] d;
        b_exp_t     e;
        int         t;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            model_big[a] = d;
            if (a < 8'd128) model_small[a] = d;
            if (!tb_in_range(a)) err = 1'b1;
        end
        bq.push_back('{id: id, resp: err});

        @(posedge clk); #1;
        AWVALID = 1'b1; AWADDR = addr; AWID = id;
        t = 0;
        @(negedge clk);
        while (!AWREADY && t < 50) begin @(negedge clk); t++; end
        check("awready", 32'(AWREADY), 32'd1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            WVALID = 1'b1;
            WDATA  = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            WLAST  = (i == n - 1);
            if (i == 0) begin
                @(negedge clk);
                check("wready_rise", 32'(WREADY), 32'd1);
            end
            @(posedge clk); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;

        @(negedge clk);
        check("bvalid_lat", 32'(BVALID), 32'd1);
        check("wready_resp", 32'(WREADY), 32'd0);
        e = bq.pop_front();
        check("bid", 32'(BID), 32'(e.id));
        check("bresp", 32'(BRESP), 32'(e.resp));
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid_hold", 32'(BVALID), 32'd1);
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        check("bvalid_drop", 32'(BVALID), 32'd0);
        check("awready_back", 32'(AWREADY), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Read burst; pat bit c is RREADY in the c-th cycle RVALID is up
    // ------------------------------------------------------------------------
    task automatic do_read(input logic [7:0] addr, input logic [3:0] len,
                           input logic [3:0] id, input logic [15:0] pat);
        logic [7:0] a;
        r_exp_t     e;
        int         t;
        int         c;
        logic       done;
        logic       took;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 8'(i);
            rq.push_back('{data: model_rd(a), resp: !tb_in_range(a),
                           last: (i == int'(len)), id: id});
        end

        @(posedge clk); #1;
        ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id;
        t = 0;
        @(negedge clk);
        while (!ARREADY && t < 50) begin @(negedge clk); t++; end
        check("arready", 32'(ARREADY), 32'd1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        @(negedge clk);
        check("rvalid_lat", 32'(RVALID), 32'd1);

        c = 0;
        done = 1'b0;
        while (!done && c < 64 && rq.size() > 0) begin
            RREADY = (c < 16) ? pat[c] : 1'b1;
            e = rq[0];
            check("rvalid", 32'(RVALID), 32'd1);
            check("rdata", 32'(RDATA), 32'(e.data));
            check("rresp", 32'(RRESP), 32'(e.resp));
            check("rlast", 32'(RLAST), 32'(e.last));
            check("rid", 32'(RID), 32'(e.id));
            took = RREADY;
            if (took) void'(rq.pop_front());
            @(posedge clk); #1;
            RREADY = 1'b0;
            @(negedge clk);
            c++;
            if (took && e.last) done = 1'b1;
        end
        check("r_done", 32'(done), 32'd1);
        check("r_beats_left", 32'(rq.size()), 32'd0);
        check("rvalid_end", 32'(RVALID), 32'd0);
        check("arready_end", 32'(ARREADY), 32'd1);
        rq.delete();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; sel_small = 1'b0;
        AWVALID = 1'b0; AWADDR = 8'h00; AWID = '0;
        WVALID = 1'b0; WDATA = 8'h00; WLAST = 1'b0; BREADY = 1'b0;
        ARVALID = 1'b0; ARADDR = 8'h00; ARLEN = 4'd0; ARID = '0; RREADY = 1'b0;
        clear_models();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(AWREADY), 32'd1);
        check("rst_arready", 32'(ARREADY), 32'd1);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rlast", 32'(RLAST), 32'd0);
        check("rst_bid", 32'(BID), 32'd0);
        check("rst_bresp", 32'(BRESP), 32'd0);
        check("rst_rid", 32'(RID), 32'd0);
        check("rst_rresp", 32'(RRESP), 32'd0);
        check("rst_rdata", 32'(RDATA), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic write then reads with RREADY held high and toggled
        do_write(8'h01, 4'd1, 3, 8'h11, 8'h22, 8'h33);
        do_read(8'h01, 4'd2, 4'd1, 16'hFFFF);
        do_read(8'h01, 4'd2, 4'd1, 16'hFFF9);

        // Wrap across 0xFF
        do_write(8'hFE, 4'd5, 3, 8'hA1, 8'hA2, 8'hA3);
        do_read(8'hFE, 4'd2, 4'd6, 16'hFFFF);
        do_read(8'h00, 4'd0, 4'd7, 16'hFFFF);

        // Out-of-range on the 128-byte instance
        sel_small = 1'b1;
        do_write(8'h7F, 4'd3, 2, 8'hB1, 8'hB2, 8'h00);
        do_read(8'h7F, 4'd1, 4'd9, 16'hFFFD);
        do_read(8'hFE, 4'd2, 4'd2, 16'hFFFF);
        sel_small = 1'b0;
        do_read(8'h7F, 4'd1, 4'd4, 16'hFFFF);

        // Reset in the middle of a read burst and the second write beat
        @(posedge clk); #1;
        ARVALID = 1'b1; ARADDR = 8'h01; ARLEN = 4'd15; ARID = 4'd3; RREADY = 1'b0;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        AWVALID = 1'b1; AWADDR = 8'h10; AWID = 4'd2;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 8'h55; WLAST = 1'b0;
        @(posedge clk); #1;
        WDATA = 8'h66;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; WVALID = 1'b0;
        clear_models();
        @(negedge clk);
        check("mid_rst_awready", 32'(AWREADY), 32'd1);
        check("mid_rst_arready", 32'(ARREADY), 32'd1);
        check("mid_rst_wready", 32'(WREADY), 32'd0);
        check("mid_rst_bvalid", 32'(BVALID), 32'd0);
        check("mid_rst_rvalid", 32'(RVALID), 32'd0);
        check("mid_rst_rlast", 32'(RLAST), 32'd0);
        do_read(8'h01, 4'd2, 4'd8, 16'hFFFF);
        do_read(8'h10, 4'd1, 4'd8, 16'hFFFF);
        do_read(8'hFE, 4'd2, 4'd8, 16'hFFFF);
        sel_small = 1'b1;
        do_read(8'h00, 4'd0, 4'd1, 16'hFFFF);
        sel_small = 1'b0;

        // Fresh traffic after reset still behaves
        do_write(8'h40, 4'd12, 1, 8'h5A, 8'h00, 8'h00);
        do_read(8'h3F, 4'd2, 4'd13, 16'hFFF5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Simplified AXI-style slave memory that sits directly downstream of the team's AXI protocol master and answers its read and write channels.
- Accepts write address/data bursts, stores bytes in an internal array and returns a write response.
- Independently accepts read address bursts and streams data back on the read-data channel.
- Gives the master bench a real target instead of hand-driven responses.

Parameters:
- DEPTH, 256, number of byte locations implemented; addresses >= DEPTH are out of range.
- ID_W, 4, width of AWID/BID/ARID/RID.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- AWVALID  input  1  write address valid
- AWREADY  output  1  write address ready
- AWADDR  input  8  write start address
- AWID  input  ID_W  write transaction ID
- WVALID  input  1  write data valid
- WREADY  output  1  write data ready
- WDATA  input  8  write data byte
- WLAST  input  1  final write beat
- BVALID  output  1  write response valid
- BREADY  input  1  write response ready
- BID  output  ID_W  echoed AWID
- BRESP  output  1  0=OKAY, 1=SLVERR
- ARVALID  input  1  read address valid
- ARREADY  output  1  read address ready
- ARADDR  input  8  read start address
- ARLEN  input  4  beats minus one
- ARID  input  ID_W  read transaction ID
- RVALID  output  1  read data valid
- RREADY  input  1  read data ready
- RDATA  output  8  read data byte
- RID  output  ID_W  echoed ARID
- RRESP  output  1  0=OKAY, 1=SLVERR for this beat
- RLAST  output  1  final read beat

Behaviour:
- Reset (synchronous, active-high, checked at the rising edge of clk):
  - Both FSMs go to IDLE and the memory array is cleared to 0x00.
  - AWREADY=1, ARREADY=1. WREADY, BVALID, RVALID and RLAST are 0. BID, BRESP, RID, RRESP and RDATA are 0.
  - Reset mid-burst aborts the burst with no B or R response, and no further writes occur.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY: latch AWADDR into waddr and AWID into BID, clear the error flag, go to W_DATA. WREADY rises the next cycle.
  - W_DATA: AWREADY=0, WREADY=1.
    - Each WVALID&WREADY cycle writes WDATA to mem[waddr] if waddr<DEPTH; otherwise the write is dropped and the error flag is set.
    - waddr increments modulo 256.
    - If WLAST is set on that beat, go to W_RESP.
  - W_RESP: WREADY=0, BVALID=1, BRESP=error flag. Hold until BREADY, then return to W_IDLE with BVALID=0 the next cycle.
  - WVALID while in W_IDLE/W_RESP is ignored (no WREADY).
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1, RVALID=0. On ARVALID&ARREADY: latch ARADDR into raddr, ARLEN into rlen and ARID into RID, and set beat count=0. Go to R_DATA.
  - The next cycle presents RVALID=1 with RDATA=mem[ARADDR], giving 1-cycle latency after the address handshake.
  - R_DATA: ARREADY=0.
    - RDATA/RRESP/RLAST are stable while RVALID&!RREADY.
    - RLAST=1 when beat count==rlen.
    - RRESP=1 and RDATA=0x00 when the current address >= DEPTH.
  - On RVALID&RREADY with !RLAST: increment raddr modulo 256 and beat count, and load the next RDATA on the same edge (back-to-back beats, no bubble).
  - On RVALID&RREADY with RLAST: go to R_IDLE, with RVALID=0 and ARREADY=1 the next cycle.
  - A burst is ARLEN+1 beats, from 1 to 16.
- Read and write FSMs run concurrently.
  - Read data is registered from the memory value before the clock edge.
  - A write and a read-fetch to the same address on the same edge return the OLD byte; the new value is visible on later fetches.
- Address wrap: a burst crossing 0xFF continues at 0x00. This is OKAY if DEPTH=256.

Test Plan:
- Reset then AW(0x01, ID 1) followed by three W beats 0x11, 0x22, 0x33, with WLAST on the third -> mem[1..3]=11,22,33; BVALID one cycle after the last beat with BID=1, BRESP=0; BVALID drops one cycle after BREADY.
- AR(0x01, ARLEN=2, ID 1) with RREADY held high -> RVALID the cycle after the handshake; RDATA 11,22,33 on consecutive cycles; RLAST only on 33; RID=1; RRESP=0.
- Same read with RREADY toggled 1,0,0,1,1 -> each beat is held stable while stalled; exactly 3 beats delivered.
- Write burst at 0xFE of 0xA1, 0xA2, 0xA3 (WLAST on the third), then read 0xFE with ARLEN=2 -> wrap: mem[FE]=A1, mem[FF]=A2, mem[00]=A3; read returns A1, A2, A3.
- DEPTH=128: write 0x7F with two beats, then read the same -> BRESP=1; mem[7F] written; beat 2 reads back 0x00 with RRESP=1.
- Assert rst during the second beat of a 3-beat write and during a read -> next cycle AWREADY=ARREADY=1, WREADY=BVALID=RVALID=0; memory reads back 0x00.
